// File: rtl/rand_hole_picker.sv
// rand_hole_picker
//
// Turns the free-running random byte stream into a uniformly chosen, currently
// unoccupied hole index for the mole spawner. Candidates are drawn by rejection
// sampling against a snapshot of the occupancy mask taken when the request is
// accepted. After MAX_TRIES rejections a one-cycle lowest-free-hole scan bounds
// the latency. If every hole is occupied at request time, fail pulses instead.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high reset
//   rand_data  random byte, new value every cycle
//   occupied   bit i set means hole i already holds a mole
//   req        pick request, only looked at while idle
//   busy       high while a pick is in progress
//   valid      one-cycle pulse, hole_idx holds a new pick
//   hole_idx   last picked hole, held until the next valid
//   fail       one-cycle pulse, all holes occupied, no pick made
//   tries      rejected samples in the last or current pick (debug)

module rand_hole_picker #(
    parameter int unsigned NUM_HOLES = 9,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           rand_data,
    input  logic [NUM_HOLES-1:0] occupied,
    input  logic                 req,
    output logic                 busy,
    output logic                 valid,
    output logic [IDX_W-1:0]     hole_idx,
    output logic                 fail,
    output logic [7:0]           tries
);

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StScan
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_HOLES-1:0]   snap_q, snap_d;
    logic [7:0]             tries_q, tries_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   fail_q, fail_d;

    logic [IDX_W-1:0]       cand;
    logic                   cand_free;
    logic [IDX_W-1:0]       first_free;
    logic [7:0]             tries_inc;
    logic                   last_try;

    assign cand = rand_data[IDX_W-1:0];

    // Upper random bits are deliberately discarded.
    if (IDX_W < 8) begin : gen_unused_rand
        logic unused_rand;
        assign unused_rand = ^rand_data[7:IDX_W];
    end

    // Candidate accepted only if it names a real hole that was free in the
    // snapshot; out-of-range values never match any loop index.
    always_comb begin
        cand_free = 1'b0;
        for (int i = 0; i < int'(NUM_HOLES); i++) begin
            if (cand == IDX_W'(i)) begin
                cand_free = ~snap_q[i];
            end
        end
    end

    // Lowest free hole: scan downwards so the smallest index wins last.
    always_comb begin
        first_free = '0;
        for (int i = int'(NUM_HOLES) - 1; i >= 0; i--) begin
            if (!snap_q[i]) begin
                first_free = IDX_W'(i);
            end
        end
    end

    assign tries_inc = tries_q + 8'd1;
    assign last_try  = (tries_inc == 8'(MAX_TRIES));

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        tries_d = tries_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        fail_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (req) begin
                    snap_d  = occupied;
                    tries_d = 8'd0;
                    if (&occupied) begin
                        fail_d = 1'b1;
                    end else begin
                        state_d = StSample;
                        busy_d  = 1'b1;
                    end
                end
            end
            StSample: begin
                if (cand_free) begin
                    idx_d   = cand;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    tries_d = tries_inc;
                    if (last_try) begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                // snap was not full at capture, so first_free is a real free hole.
                idx_d   = first_free;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            snap_q  <= '0;
            tries_q <= 8'd0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            tries_q <= tries_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign fail     = fail_q;
    assign hole_idx = idx_q;
    assign tries    = tries_q;

endmodule

// File: tb/tb_rand_hole_picker.sv
module tb_rand_hole_picker;

    localparam int unsigned NUM_HOLES = 9;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned MAX_TRIES = 16;

    logic                 clock;
    logic                 reset;
    logic [7:0]           rand_data;
    logic [NUM_HOLES-1:0] occupied;
    logic                 req;
    logic                 busy;
    logic                 valid;
    logic [IDX_W-1:0]     hole_idx;
    logic                 fail;
    logic [7:0]           tries;

    int vectors;
    int miscompares;

    rand_hole_picker #(
        .NUM_HOLES (NUM_HOLES),
        .IDX_W     (IDX_W),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rand_data (rand_data),
        .occupied  (occupied),
        .req       (req),
        .busy      (busy),
        .valid     (valid),
        .hole_idx  (hole_idx),
        .fail      (fail),
        .tries     (tries)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a pick is either in progress or not; while in progress
    // each cycle either takes the random hole or counts a rejection, and after
    // MAX_TRIES rejections the next cycle settles on the lowest free hole.
    bit                   m_started;
    bit                   m_picking;
    bit                   m_fallback_due;
    bit [NUM_HOLES-1:0]   m_snap;
    int                   m_rejects;
    bit                   m_busy;
    bit                   m_valid;
    bit                   m_fail;
    int                   m_idx;

    function automatic int lowest_free(input bit [NUM_HOLES-1:0] mask);
        for (int i = 0; i < int'(NUM_HOLES); i++) begin
            if (mask[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        int c;
        m_valid = 1'b0;
        m_fail  = 1'b0;
        if (reset) begin
            m_started      = 1'b1;
            m_picking      = 1'b0;
            m_fallback_due = 1'b0;
            m_snap         = '0;
            m_rejects      = 0;
            m_busy         = 1'b0;
            m_idx          = 0;
        end else if (!m_picking) begin
            if (req) begin
                m_snap    = occupied;
                m_rejects = 0;
                if (lowest_free(occupied) < 0) begin
                    m_fail = 1'b1;
                end else begin
                    m_picking      = 1'b1;
                    m_fallback_due = 1'b0;
                    m_busy         = 1'b1;
                end
            end
        end else if (m_fallback_due) begin
            m_idx     = lowest_free(m_snap);
            m_valid   = 1'b1;
            m_busy    = 1'b0;
            m_picking = 1'b0;
        end else begin
            c = int'(rand_data) % (1 << IDX_W);
            if (c < int'(NUM_HOLES) && m_snap[c] == 1'b0) begin
                m_idx     = c;
                m_valid   = 1'b1;
                m_busy    = 1'b0;
                m_picking = 1'b0;
            end else begin
                m_rejects = m_rejects + 1;
                if (m_rejects == int'(MAX_TRIES)) m_fallback_due = 1'b1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, on the falling edge.
    always @(negedge clock) begin
        if (m_started) begin
            vectors++;
            if (busy !== m_busy) begin
                miscompares++;
                $display("FAIL model_busy t=%0t got %b want %b", $time, busy, m_busy);
            end
            if (valid !== m_valid) begin
                miscompares++;
                $display("FAIL model_valid t=%0t got %b want %b", $time, valid, m_valid);
            end
            if (fail !== m_fail) begin
                miscompares++;
                $display("FAIL model_fail t=%0t got %b want %b", $time, fail, m_fail);
            end
            if (hole_idx !== IDX_W'(m_idx)) begin
                miscompares++;
                $display("FAIL model_hole_idx t=%0t got %0d want %0d", $time, hole_idx, m_idx);
            end
            if (tries !== 8'(m_rejects)) begin
                miscompares++;
                $display("FAIL model_tries t=%0t got %0d want %0d", $time, tries, m_rejects);
            end
            if (valid === 1'b1 && fail === 1'b1) begin
                miscompares++;
                $display("FAIL valid_and_fail t=%0t got both high want at most one", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req         = 1'b0;
        occupied    = '0;
        rand_data   = 8'h00;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_fail", 32'(fail), 32'd0);
        check("reset_hole_idx", 32'(hole_idx), 32'd0);
        check("reset_tries", 32'(tries), 32'd0);
        reset = 1'b0;
        tick();

        // Immediate accept: 8'h25 -> candidate 5, free.
        occupied  = 9'h000;
        req       = 1'b1;
        rand_data = 8'h25;
        tick();
        req = 1'b0;
        check("accept_busy_after_req", 32'(busy), 32'd1);
        check("accept_no_valid_yet", 32'(valid), 32'd0);
        tick();
        check("accept_valid", 32'(valid), 32'd1);
        check("accept_hole_idx", 32'(hole_idx), 32'd5);
        check("accept_tries", 32'(tries), 32'd0);
        check("accept_busy_clear", 32'(busy), 32'd0);
        tick();
        check("accept_valid_pulse", 32'(valid), 32'd0);
        check("accept_idx_held", 32'(hole_idx), 32'd5);

        // Rejections: 15 out of range, 5 occupied, 3 accepted.
        occupied  = 9'h020;
        req       = 1'b1;
        rand_data = 8'h0F;
        tick();
        req = 1'b0;
        tick();
        check("reject_tries_1", 32'(tries), 32'd1);
        rand_data = 8'h05;
        tick();
        check("reject_tries_2", 32'(tries), 32'd2);
        check("reject_still_busy", 32'(busy), 32'd1);
        rand_data = 8'h03;
        tick();
        check("reject_valid", 32'(valid), 32'd1);
        check("reject_hole_idx", 32'(hole_idx), 32'd3);
        check("reject_tries_final", 32'(tries), 32'd2);
        tick();

        // All full: fail pulse, no busy, hole_idx stays 3.
        occupied = 9'h1FF;
        req      = 1'b1;
        tick();
        req = 1'b0;
        check("full_fail", 32'(fail), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        check("full_valid", 32'(valid), 32'd0);
        check("full_idx_held", 32'(hole_idx), 32'd3);
        tick();
        check("full_fail_pulse", 32'(fail), 32'd0);
        check("full_busy_after", 32'(busy), 32'd0);

        // Fallback: only hole 0 free, random candidate 12 always out of range.
        occupied  = 9'h1FE;
        rand_data = 8'h0C;
        req       = 1'b1;
        tick();
        req = 1'b0;
        for (int n = 1; n <= int'(MAX_TRIES); n++) begin
            tick();
            check("fallback_no_early_valid", 32'(valid), 32'd0);
        end
        check("fallback_tries_16", 32'(tries), 32'd16);
        check("fallback_busy", 32'(busy), 32'd1);
        tick();
        check("fallback_valid", 32'(valid), 32'd1);
        check("fallback_hole_idx", 32'(hole_idx), 32'd0);
        check("fallback_tries", 32'(tries), 32'd16);
        tick();

        // Snapshot + req while busy ignored.
        occupied  = 9'h000;
        req       = 1'b1;
        rand_data = 8'h0F;
        tick();
        occupied = 9'h1FF;
        tick();
        check("snap_busy_req_ignored", 32'(busy), 32'd1);
        req       = 1'b0;
        rand_data = 8'h02;
        tick();
        check("snap_valid", 32'(valid), 32'd1);
        check("snap_hole_idx", 32'(hole_idx), 32'd2);
        tick();
        check("busy_req_not_queued", 32'(busy), 32'd0);
        check("busy_req_no_fail", 32'(fail), 32'd0);

        // req held through valid starts a new pick straight away.
        occupied  = 9'h000;
        req       = 1'b1;
        rand_data = 8'h01;
        tick();
        tick();
        check("b2b_first_valid", 32'(valid), 32'd1);
        check("b2b_first_idx", 32'(hole_idx), 32'd1);
        rand_data = 8'h04;
        tick();
        check("b2b_restart_busy", 32'(busy), 32'd1);
        req = 1'b0;
        tick();
        check("b2b_second_valid", 32'(valid), 32'd1);
        check("b2b_second_idx", 32'(hole_idx), 32'd4);
        tick();

        // Reset mid-pick aborts without any pulse.
        occupied  = 9'h000;
        req       = 1'b1;
        rand_data = 8'h0F;
        tick();
        req = 1'b0;
        tick();
        check("midreset_pre_tries", 32'(tries), 32'd1);
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_fail", 32'(fail), 32'd0);
        check("midreset_idx", 32'(hole_idx), 32'd0);
        check("midreset_tries", 32'(tries), 32'd0);
        reset     = 1'b0;
        rand_data = 8'h03;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("midreset_no_pulse", 32'(valid | fail), 32'd0);
            check("midreset_idle", 32'(busy), 32'd0);
        end

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
